// File: rtl/fu_issue_dispatch_pkg.sv
// Shared types for the issue-dispatch slice: functional-unit encoding, operand bus,
// branch prediction side-band and the packed issue entry held between scoreboard and ex_stage.
package fu_issue_dispatch_pkg;

  localparam int TRANS_ID_BITS = 3;
  localparam int NUM_UNITS     = 6;

  typedef enum logic [3:0] {
    NONE, LOAD, STORE, ALU, CTRL_FLOW, MULT, CSR, FPU, FPU_VEC
  } fu_t;

  // Strobe index of each unit in the one-hot dispatch vector
  typedef enum logic [2:0] {
    U_ALU, U_BRANCH, U_CSR, U_MULT, U_LSU, U_FPU
  } unit_e;

  typedef struct packed {
    fu_t                      fu;
    logic [6:0]               operator;
    logic [63:0]              operand_a;
    logic [63:0]              operand_b;
    logic [63:0]              imm;
    logic [TRANS_ID_BITS-1:0] trans_id;
  } fu_data_t;

  typedef struct packed {
    logic [1:0]  cf;
    logic [63:0] predict_address;
  } branchpredict_sbe_t;

  typedef struct packed {
    fu_t                fu;
    fu_data_t           data;
    logic [63:0]        pc;
    logic               is_compressed;
    branchpredict_sbe_t branch_predict;
    logic [1:0]         fpu_fmt;
    logic [2:0]         fpu_rm;
    logic [2:0]         fpu_frm;
    logic [6:0]         fpu_prec;
  } issue_entry_t;

  function automatic unit_e fu_to_unit(fu_t fu);
    unit_e u;
    case (fu)
      CTRL_FLOW:     u = U_BRANCH;
      CSR:           u = U_CSR;
      MULT:          u = U_MULT;
      LOAD, STORE:   u = U_LSU;
      FPU, FPU_VEC:  u = U_FPU;
      default:       u = U_ALU;
    endcase
    return u;
  endfunction

endpackage

// File: rtl/fu_issue_dispatch_issue_hazard_check.sv
// Combinational readiness check: decides whether the held instruction's unit can take it
// this cycle and names that unit as a one-hot vector.
module issue_hazard_check
  import fu_issue_dispatch_pkg::*;
#(
  parameter bit FpPresent = 1'b1
) (
  input  fu_t                  fu_i,
  input  logic                 flu_ready_i,
  input  logic                 lsu_ready_i,
  input  logic                 fpu_ready_i,
  input  logic                 mult_busy_i,
  output logic                 can_issue_o,
  output logic [NUM_UNITS-1:0] unit_sel_o
);

  unit_e unit;

  assign unit = fu_to_unit(fu_i);

  for (genvar gi = 0; gi < NUM_UNITS; gi++) begin : g_sel
    assign unit_sel_o[gi] = (unit == unit_e'(gi));
  end

  // Single-cycle FLU classes would collide with a mult result landing on the write-back port
  always_comb begin
    can_issue_o = 1'b0;
    case (unit)
      U_ALU, U_BRANCH, U_CSR: can_issue_o = flu_ready_i & ~mult_busy_i;
      U_MULT:                 can_issue_o = flu_ready_i;
      U_LSU:                  can_issue_o = lsu_ready_i;
      U_FPU:                  can_issue_o = fpu_ready_i & FpPresent;
      default:                can_issue_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/fu_issue_dispatch.sv
// One-entry issue buffer that routes the held instruction to a single functional unit,
// tracking in-flight mults so fixed-latency write-backs never collide.
module fu_issue_dispatch
  import fu_issue_dispatch_pkg::*;
#(
  parameter bit          FpPresent   = 1'b1,
  parameter int unsigned MultLatency = 1
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               flush_i,
  input  logic               issue_valid_i,
  input  issue_entry_t       issue_entry_i,
  output logic               issue_ack_o,
  output fu_data_t           fu_data_o,
  output logic [63:0]        pc_o,
  output logic               is_compressed_o,
  output branchpredict_sbe_t branch_predict_o,
  output logic [1:0]         fpu_fmt_o,
  output logic [2:0]         fpu_rm_o,
  output logic [2:0]         fpu_frm_o,
  output logic [6:0]         fpu_prec_o,
  output logic               alu_valid_o,
  output logic               branch_valid_o,
  output logic               csr_valid_o,
  output logic               mult_valid_o,
  output logic               lsu_valid_o,
  output logic               fpu_valid_o,
  input  logic               flu_ready_i,
  input  logic               lsu_ready_i,
  input  logic               fpu_ready_i,
  output logic               issue_stall_o
);

  logic                   entry_valid_q, entry_valid_d;
  issue_entry_t           entry_q, entry_d;
  logic [MultLatency-1:0] mult_sr_q, mult_sr_d;
  logic                   can_issue, fire, kill, mult_fire;
  logic [NUM_UNITS-1:0]   unit_sel, strobe;

  issue_hazard_check #(
    .FpPresent (FpPresent)
  ) u_hazard (
    .fu_i        (entry_q.fu),
    .flu_ready_i (flu_ready_i),
    .lsu_ready_i (lsu_ready_i),
    .fpu_ready_i (fpu_ready_i),
    .mult_busy_i (mult_sr_q[MultLatency-1]),
    .can_issue_o (can_issue),
    .unit_sel_o  (unit_sel)
  );

  // Reset and flush discard the held entry instead of dispatching it
  assign kill      = rst_i | flush_i;
  assign fire      = entry_valid_q & can_issue & ~kill;
  assign strobe    = {NUM_UNITS{fire}} & unit_sel;
  assign mult_fire = strobe[U_MULT];

  assign issue_ack_o   = issue_valid_i & ~kill & (~entry_valid_q | fire);
  assign issue_stall_o = entry_valid_q & ~fire;

  if (MultLatency == 1) begin : g_sr_one
    assign mult_sr_d = mult_fire;
  end else begin : g_sr_many
    assign mult_sr_d = {mult_sr_q[MultLatency-2:0], mult_fire};
  end

  always_comb begin
    entry_d       = entry_q;
    entry_valid_d = entry_valid_q;
    if (issue_ack_o) begin
      entry_d       = issue_entry_i;
      entry_valid_d = 1'b1;
    end else if (fire) begin
      entry_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (kill) begin
      entry_valid_q <= 1'b0;
      entry_q       <= '0;
      mult_sr_q     <= '0;
    end else begin
      entry_valid_q <= entry_valid_d;
      entry_q       <= entry_d;
      mult_sr_q     <= mult_sr_d;
    end
  end

  assign fu_data_o        = entry_q.data;
  assign pc_o             = entry_q.pc;
  assign is_compressed_o  = entry_q.is_compressed;
  assign branch_predict_o = entry_q.branch_predict;
  assign fpu_fmt_o        = entry_q.fpu_fmt;
  assign fpu_rm_o         = entry_q.fpu_rm;
  assign fpu_frm_o        = entry_q.fpu_frm;
  assign fpu_prec_o       = entry_q.fpu_prec;

  assign alu_valid_o    = strobe[U_ALU];
  assign branch_valid_o = strobe[U_BRANCH];
  assign csr_valid_o    = strobe[U_CSR];
  assign mult_valid_o   = strobe[U_MULT];
  assign lsu_valid_o    = strobe[U_LSU];
  assign fpu_valid_o    = strobe[U_FPU];

endmodule

// File: tb/tb_fu_issue_dispatch.sv
// Scoreboard bench: a cycle model predicts accept/stall/dispatch timing; accepted entries are
// queued and a negedge monitor pops and compares them whenever a unit strobe appears.
module tb_fu_issue_dispatch;
  import fu_issue_dispatch_pkg::*;

  localparam bit FP_PRESENT = 1'b1;
  localparam int MULT_LAT   = 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, flush, issue_valid, issue_ack, is_compressed;
  issue_entry_t issue_entry;
  fu_data_t fu_data;
  logic [63:0] pc;
  branchpredict_sbe_t bp;
  logic [1:0] fpu_fmt;
  logic [2:0] fpu_rm, fpu_frm;
  logic [6:0] fpu_prec;
  logic alu_v, br_v, csr_v, mul_v, lsu_v, fpu_v;
  logic flu_rdy, lsu_rdy, fpu_rdy, stall;

  fu_issue_dispatch #(.FpPresent(FP_PRESENT), .MultLatency(MULT_LAT)) dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .issue_valid_i(issue_valid),
    .issue_entry_i(issue_entry), .issue_ack_o(issue_ack), .fu_data_o(fu_data), .pc_o(pc),
    .is_compressed_o(is_compressed), .branch_predict_o(bp), .fpu_fmt_o(fpu_fmt),
    .fpu_rm_o(fpu_rm), .fpu_frm_o(fpu_frm), .fpu_prec_o(fpu_prec),
    .alu_valid_o(alu_v), .branch_valid_o(br_v), .csr_valid_o(csr_v), .mult_valid_o(mul_v),
    .lsu_valid_o(lsu_v), .fpu_valid_o(fpu_v), .flu_ready_i(flu_rdy), .lsu_ready_i(lsu_rdy),
    .fpu_ready_i(fpu_rdy), .issue_stall_o(stall)
  );

  int tests = 0;
  int fails = 0;

  // Reference state: at most one held instruction, plus the cycle of the last mult dispatch
  bit           m_held = 1'b0;
  issue_entry_t m_entry = '0;
  int           m_last_mult = -100;
  int           cyc = 0;
  issue_entry_t exp_q[$];

  function automatic int unit_of(fu_t f);
    case (f)
      CTRL_FLOW:    return 1;
      CSR:          return 2;
      MULT:         return 3;
      LOAD, STORE:  return 4;
      FPU, FPU_VEC: return 5;
      default:      return 0;
    endcase
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic step(input bit v, input fu_t f, input int tid, input bit flu, input bit lsu,
                      input bit fpu, input bit fl, input bit rs);
    issue_entry_t e;
    int u;
    bit rdy, fire_m, ack_m;
    logic [5:0] sv;
    @(posedge clk);
    #1;
    e = '0;
    e.fu = f;
    e.data.fu = f;
    e.data.operator = 7'($urandom);
    e.data.operand_a = {$urandom, $urandom};
    e.data.operand_b = {$urandom, $urandom};
    e.data.imm = {$urandom, $urandom};
    e.data.trans_id = tid[2:0];
    e.pc = {$urandom, $urandom};
    e.is_compressed = 1'($urandom);
    e.branch_predict.cf = 2'($urandom);
    e.branch_predict.predict_address = {$urandom, $urandom};
    e.fpu_fmt = 2'($urandom);
    e.fpu_rm = 3'($urandom);
    e.fpu_frm = 3'($urandom);
    e.fpu_prec = 7'($urandom);
    issue_valid = v; issue_entry = e; flu_rdy = flu; lsu_rdy = lsu; fpu_rdy = fpu;
    flush = fl; rst = rs;
    #1;
    u = unit_of(m_entry.fu);
    case (u)
      0, 1, 2: rdy = flu && (cyc != m_last_mult + MULT_LAT);
      3:       rdy = flu;
      4:       rdy = lsu;
      default: rdy = fpu && FP_PRESENT;
    endcase
    fire_m = m_held && !fl && !rs && rdy;
    ack_m  = v && !fl && !rs && (!m_held || fire_m);
    sv = {fpu_v, lsu_v, mul_v, csr_v, br_v, alu_v};
    check("ack", 64'(issue_ack), 64'(ack_m));
    check("stall", 64'(stall), 64'(m_held && !fire_m));
    check("strobes", 64'(sv), fire_m ? (64'd1 << u) : 64'd0);
    if (m_held) check("hold_pc", pc, m_entry.pc);
    if (fl || rs) begin
      if (m_held) void'(exp_q.pop_back());
      m_held = 1'b0;
      m_entry = '0;
      m_last_mult = -100;
    end else begin
      if (fire_m && u == 3) m_last_mult = cyc;
      if (ack_m) begin
        m_held = 1'b1;
        m_entry = e;
        exp_q.push_back(e);
      end else if (fire_m) begin
        m_held = 1'b0;
      end
    end
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, ALU, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
  endtask

  // Monitor: every strobe must match the oldest accepted, not-yet-dispatched entry
  always @(negedge clk) begin : monitor
    logic [5:0] sv;
    issue_entry_t ex;
    sv = {fpu_v, lsu_v, mul_v, csr_v, br_v, alu_v};
    if (sv != 6'd0) begin
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 64'(sv), 64'd0);
      end else begin
        ex = exp_q.pop_front();
        $display("[TB] dispatch cycle=%0d unit_vec=%b trans_id=%0d pc=%h", cyc, sv,
                 fu_data.trans_id, pc);
        check("disp_unit", 64'(sv), 64'd1 << unit_of(ex.fu));
        check("disp_tid", 64'(fu_data.trans_id), 64'(ex.data.trans_id));
        check("disp_pc", pc, ex.pc);
        check("disp_opa", fu_data.operand_a, ex.data.operand_a);
        check("disp_side", {is_compressed, bp.cf, fpu_fmt, fpu_rm, fpu_frm, fpu_prec},
              {ex.is_compressed, ex.branch_predict.cf, ex.fpu_fmt, ex.fpu_rm, ex.fpu_frm,
               ex.fpu_prec});
      end
    end
  end

  initial begin
    fu_t f;
    rst = 1'b1; flush = 1'b0; issue_valid = 1'b0; issue_entry = '0;
    flu_rdy = 1'b0; lsu_rdy = 1'b0; fpu_rdy = 1'b0;
    step(1'b0, ALU, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, ALU, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(1);
    check("rst_fu_data", 64'(|fu_data), 64'd0);
    check("rst_pc", pc, 64'd0);
    check("rst_side", {is_compressed, bp, fpu_fmt, fpu_rm, fpu_frm, fpu_prec}, 64'd0);

    // single ALU
    step(1'b1, ALU, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    // mult followed by ALU hits the write-back collision window
    step(1'b1, MULT, 1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, ALU, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(3);
    // LSU back-pressure
    step(1'b1, LOAD, 5, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b1, ALU, 6, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(3);
    // streaming
    for (int i = 0; i < 8; i++) step(1'b1, ALU, i, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);
    // flush while a CSR is stuck
    step(1'b1, CSR, 4, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, ALU, 7, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, ALU, 1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle(2);
    // reset right after a mult dispatch
    step(1'b1, MULT, 2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, ALU, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, ALU, 0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    step(1'b1, ALU, 3, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    idle(2);

    for (int i = 0; i < 3000; i++) begin
      f = fu_t'($urandom_range(0, 8));
      step($urandom_range(0, 9) < 7, f, i, $urandom_range(0, 9) < 8,
           $urandom_range(0, 9) < 7, $urandom_range(0, 9) < 7,
           $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 2);
    end
    idle(4);
    check("drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
